// File: rtl/maria_ready_ctrl_if.sv
// Bundle of the MARIA RDY/halt control signals between register decode,
// DMA sequencer, CPU RDY input and the ready controller.
// master: the surrounding system that drives strobes and requests.
// slave:  maria_ready_ctrl, which returns ready/halt_ack/hpos/line_start.
interface maria_ready_ctrl_if;
    logic       mclk0;
    logic       pclk0;
    logic       maria_en;
    logic       deassert_ready;
    logic       dma_req;
    logic       halt_ack;
    logic       ready;
    logic [8:0] hpos;
    logic       line_start;

    modport master (
        output mclk0,
        output pclk0,
        output maria_en,
        output deassert_ready,
        output dma_req,
        input  halt_ack,
        input  ready,
        input  hpos,
        input  line_start
    );

    modport slave (
        input  mclk0,
        input  pclk0,
        input  maria_en,
        input  deassert_ready,
        input  dma_req,
        output halt_ack,
        output ready,
        output hpos,
        output line_start
    );
endinterface

// File: rtl/maria_ready_ctrl.sv
// MARIA 6502 RDY generator: horizontal position counter, WSYNC hold and
// DMA bus-halt arbitration against CPU cycle boundaries.
// Optional macro MARIA_HALT_ALIGN_EN: when defined, halt grant and ready
// release are aligned to pclk0 strobes; when undefined, both act on the
// first clk_sys their conditions hold.
module maria_ready_ctrl #(
    parameter int unsigned LINE_LEN      = 454,
    parameter int unsigned WSYNC_RELEASE = 0
) (
    input logic               clk_sys,
    input logic               reset_n,
    maria_ready_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        StRun      = 2'd0,
        StHaltPend = 2'd1,
        StHalted   = 2'd2
    } state_e;

    localparam logic [8:0] HposLast    = 9'(LINE_LEN - 1);
    localparam logic [8:0] HposRelease = 9'(WSYNC_RELEASE);

    logic [8:0] hpos_q, hpos_d;
    logic       line_start_q, line_start_d;
    logic       dr_q;
    logic       wsync_q, wsync_d;
    state_e     state_q, state_d;
    logic       ready_q, ready_d;
    logic       halt_ack_q, halt_ack_d;
    logic       arm;
    logic       release_hit;
    logic       hold;
    logic       rise_ok;

    // Line position counter; line_start marks the wrap in the same update.
    always_comb begin
        hpos_d       = hpos_q;
        line_start_d = 1'b0;
        if (bus.mclk0) begin
            if (hpos_q == HposLast) begin
                hpos_d       = '0;
                line_start_d = 1'b1;
            end else begin
                hpos_d = hpos_q + 9'd1;
            end
        end
    end

    // WSYNC hold: armed by a rising edge of deassert_ready, released when
    // hpos steps onto the release point. Arming wins over a same-cycle release.
    always_comb begin
        arm         = bus.maria_en & bus.deassert_ready & ~dr_q;
        release_hit = bus.mclk0 & (hpos_d == HposRelease);
        wsync_d     = wsync_q;
        if (!bus.maria_en) begin
            wsync_d = 1'b0;
        end else if (arm) begin
            wsync_d = 1'b1;
        end else if (release_hit) begin
            wsync_d = 1'b0;
        end
    end

    // DMA halt next-state; 2600 mode forces RUN.
    always_comb begin
        state_d = state_q;
        if (!bus.maria_en) begin
            state_d = StRun;
        end else begin
            case (state_q)
                StRun: begin
                    if (bus.dma_req) begin
`ifdef MARIA_HALT_ALIGN_EN
                        state_d = StHaltPend;
`else
                        state_d = StHalted;
`endif
                    end
                end
                StHaltPend: begin
                    // A dropped request wins over a same-cycle pclk0.
                    if (!bus.dma_req) begin
                        state_d = StRun;
                    end else if (bus.pclk0) begin
                        state_d = StHalted;
                    end
                end
                StHalted: begin
                    if (!bus.dma_req) begin
                        state_d = StRun;
                    end
                end
                default: state_d = StRun;
            endcase
        end
    end

    // Registered outputs: ready may only rise on a CPU cycle boundary unless
    // the block is in 2600 mode.
    always_comb begin
`ifdef MARIA_HALT_ALIGN_EN
        rise_ok = bus.pclk0;
`else
        rise_ok = 1'b1;
`endif
        hold       = wsync_d | (state_d != StRun);
        halt_ack_d = (state_d == StHalted);
        ready_d    = 1'b0;
        if (!hold) begin
            ready_d = ready_q | ~bus.maria_en | rise_ok;
        end
    end

    // State registers.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            hpos_q       <= '0;
            line_start_q <= 1'b0;
            dr_q         <= 1'b0;
            wsync_q      <= 1'b0;
            state_q      <= StRun;
            ready_q      <= 1'b1;
            halt_ack_q   <= 1'b0;
        end else begin
            hpos_q       <= hpos_d;
            line_start_q <= line_start_d;
            dr_q         <= bus.deassert_ready;
            wsync_q      <= wsync_d;
            state_q      <= state_d;
            ready_q      <= ready_d;
            halt_ack_q   <= halt_ack_d;
        end
    end

    assign bus.hpos       = hpos_q;
    assign bus.line_start = line_start_q;
    assign bus.ready      = ready_q;
    assign bus.halt_ack   = halt_ack_q;

endmodule

// File: doc/maria_ready_ctrl.md
# maria_ready_ctrl

Generates the 6502 RDY line for the MARIA side of the system. It takes the WSYNC strobe (`deassert_ready`) produced by the MARIA register/decode stage, keeps a horizontal line position counter, and releases the CPU at a fixed point in the next scanline. It also arbitrates the DMA engine's bus-halt request against CPU cycle boundaries. It sits directly downstream of the register decode block and upstream of the CPU core RDY input and the MARIA DMA sequencer.

## Interface
Parameters:
- `LINE_LEN`, 454: mclk0 strobes per scanline; hpos counts 0..LINE_LEN-1.
- `WSYNC_RELEASE`, 0: hpos value at which a pending WSYNC hold is released.

Ports:
- `clk_sys` in 1: system clock; all state is on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `mclk0` in 1: MARIA pixel-clock enable strobe, one clk_sys wide.
- `pclk0` in 1: CPU cycle-boundary enable strobe, one clk_sys wide.
- `maria_en` in 1: 7800 mode; 0 = 2600 mode.
- `deassert_ready` in 1: WSYNC write indication from register decode; a level that may stay high for several clk_sys cycles.
- `dma_req` in 1: level request from the DMA engine for bus ownership.
- `halt_ack` out 1: bus granted to DMA; CPU is halted.
- `ready` out 1: CPU RDY; 1 = run.
- `hpos` out 9: current horizontal position.
- `line_start` out 1: one-clk_sys pulse when hpos wraps to 0.

## Operation
- Reset values (async, reset_n low):
  - outputs: hpos=0, ready=1, halt_ack=0, line_start=0
  - internal: wsync_hold=0, state=RUN, deassert_ready edge register=0
- hpos:
  - Increments on each clk_sys with mclk0=1.
  - On an mclk0 strobe at LINE_LEN-1, hpos wraps to 0 and line_start pulses in the same registered update.
  - hpos counts regardless of maria_en.
- WSYNC:
  - A rising edge of `deassert_ready` (registered-previous 0, current 1) sets wsync_hold. The level is not re-armed while it stays high.
  - wsync_hold clears on the mclk0 strobe that moves hpos to WSYNC_RELEASE.
  - Simultaneous arm and release in one cycle: arm wins. The hold remains until the next occurrence of WSYNC_RELEASE, a full line later.
- DMA halt state machine, states RUN, HALT_PEND, HALTED:
  - RUN → HALT_PEND when dma_req=1.
  - HALT_PEND → HALTED on a cycle with pclk0=1; halt_ack=1 from that transition onward.
  - HALT_PEND → RUN if dma_req drops before pclk0. No ack is issued.
  - HALTED → RUN when dma_req=0; halt_ack drops on the same registered update.
  - dma_req may assert while wsync_hold=1. The halt proceeds normally and the two holds are ORed.
- ready:
  - Registered: ready = ~(wsync_hold_next | state_next != RUN).
  - Rising transitions of ready occur only on cycles with pclk0=1. If a release condition is met between strobes, ready stays 0 until the next pclk0.
- maria_en=0:
  - wsync_hold is forced to 0 and deassert_ready is ignored.
  - dma_req is ignored and the state is forced to RUN.
  - Outputs: halt_ack=0, ready=1.
  - Changing maria_en mid-halt drops halt_ack and raises ready on the next clk_sys; this path is not gated by pclk0.

## Timing
- deassert_ready rising edge to ready=0: 1 clk_sys.
- dma_req to halt_ack: 1 clk_sys after the first pclk0 cycle following the request (HALT_PEND entry, then pclk0).
- dma_req falling to halt_ack=0: 1 clk_sys.
- dma_req falling to ready=1: the next pclk0 cycle after RUN is reached, provided wsync_hold=0.
- line_start and hpos change in the same clk_sys.
- Reset deasserted mid-line restarts hpos at 0. No pending hold survives reset.

## Configuration
- `MARIA_HALT_ALIGN_EN`:
  - Defined: halt_ack is granted only on a pclk0 cycle and ready rises only on pclk0 cycles, as above.
  - Undefined: HALT_PEND is skipped. RUN → HALTED on the first clk_sys with dma_req=1, and ready rises on the first clk_sys the release conditions hold, with no pclk0 gating.

## Test plan
- Reset, then 2 × 454 mclk0 strobes: hpos reaches 453 then 0; line_start pulses exactly twice; ready=1 throughout.
- deassert_ready held high for 3 clk_sys at hpos=100: ready=0 one clk later. Ready returns to 1 on the first pclk0 at or after hpos reaching 0, single arming only.
- deassert_ready rising on the same cycle hpos steps to WSYNC_RELEASE: ready stays 0 for a further full line (454 strobes).
- dma_req=1 with pclk0 every 4 clk_sys:
  - halt_ack=1 within 5 clk_sys.
  - Dropping dma_req gives halt_ack=0 next clk and ready=1 at the next pclk0.
  - Repeat without MARIA_HALT_ALIGN_EN: halt_ack=1 after 1 clk.
- maria_en=0 with deassert_ready and dma_req toggling: ready=1 and halt_ack=0 constantly; hpos still counts.
- reset_n pulsed low asynchronously while HALTED with wsync_hold=1: immediately ready=1, halt_ack=0, hpos=0.
